// File: rtl/ysyx_23060203_ifu.sv
// ----------------------------------------------------------------------------
// ysyx_23060203_ifu -- single-issue instruction fetch unit
//
// Holds the architectural PC, issues one AXI4-Lite-style read per instruction,
// hands the fetched word and its PC to decode over a valid/ready handshake,
// then waits for the next PC from execute/writeback before fetching again.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   ifu_araddr/arvalid/arready   read address channel (araddr = pc)
//   ifu_rdata/rresp/rvalid/rready read data channel (rresp 2'b00 = OKAY)
//   out_valid/out_ready      handshake to decode
//   out_inst, out_pc, out_err    fetched word, its PC, non-OKAY response flag
//   npc_valid, npc           next PC from execute/writeback
//   fetch_cnt                number of instructions accepted by decode
// ----------------------------------------------------------------------------
module ysyx_23060203_ifu #(
    parameter logic [31:0] RESET_PC = 32'h80000000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] ifu_araddr,
    output logic        ifu_arvalid,
    input  logic        ifu_arready,
    input  logic [31:0] ifu_rdata,
    input  logic [1:0]  ifu_rresp,
    input  logic        ifu_rvalid,
    output logic        ifu_rready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_err,
    input  logic        npc_valid,
    input  logic [31:0] npc,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [1:0] {
        S_AR   = 2'd0,   // address phase
        S_R    = 2'd1,   // data phase
        S_OUT  = 2'd2,   // presenting inst/pc to decode
        S_WAIT = 2'd3    // waiting for next PC
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] inst_reg, inst_next;
    logic        err_reg, err_next;
    logic [31:0] fetch_cnt_reg, fetch_cnt_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_AR;
            pc_reg        <= RESET_PC;
            inst_reg      <= 32'd0;
            err_reg       <= 1'b0;
            fetch_cnt_reg <= 32'd0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            inst_reg      <= inst_next;
            err_reg       <= err_next;
            fetch_cnt_reg <= fetch_cnt_next;
        end
    end

    // pc only moves in S_OUT/S_WAIT, so the address and the reported PC
    // can never change while a read is outstanding.
    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        inst_next      = inst_reg;
        err_next       = err_reg;
        fetch_cnt_next = fetch_cnt_reg;
        case (state_reg)
            S_AR: begin
                if (ifu_arready) begin
                    state_next = S_R;
                end
            end
            S_R: begin
                if (ifu_rvalid) begin
                    inst_next  = ifu_rdata;
                    err_next   = (ifu_rresp != 2'b00);
                    state_next = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    fetch_cnt_next = fetch_cnt_reg + 32'd1;
                    // Next PC arriving together with the handshake skips S_WAIT.
                    if (npc_valid) begin
                        pc_next    = npc;
                        state_next = S_AR;
                    end else begin
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (npc_valid) begin
                    pc_next    = npc;
                    state_next = S_AR;
                end
            end
            default: begin
                state_next = S_AR;
            end
        endcase
    end

    // Handshake outputs are pure state decodes, gated off while rst is high.
    assign ifu_arvalid = !rst && (state_reg == S_AR);
    assign ifu_rready  = !rst && (state_reg == S_R);
    assign out_valid   = !rst && (state_reg == S_OUT);
    assign ifu_araddr  = pc_reg;
    assign out_pc      = pc_reg;
    assign out_inst    = inst_reg;
    assign out_err     = err_reg;
    assign fetch_cnt   = fetch_cnt_reg;

endmodule
